// File: rtl/reg_wb_queue.sv
// Dual-port write-back queue feeding the GR file in program order, with a pending-write mask.
// Latency: enqueue at edge N, on the write port in cycle N+1; backpressure: in_ready drops when fewer than two slots are free.
`ifndef GRLEN
`define GRLEN 32
`endif

module reg_wb_queue #(
    parameter int DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in0_valid,
    input  logic [4:0]        in0_addr,
    input  logic [`GRLEN-1:0] in0_data,
    input  logic              in1_valid,
    input  logic [4:0]        in1_addr,
    input  logic [`GRLEN-1:0] in1_data,
    output logic              in_ready,
    output logic [4:0]        waddr1,
    output logic              wen1,
    output logic [`GRLEN-1:0] wdata1,
    output logic [4:0]        waddr2,
    output logic              wen2,
    output logic [`GRLEN-1:0] wdata2,
    output logic [31:0]       busy_mask,
    output logic              empty
);

    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [4:0]        addr;
        logic [`GRLEN-1:0] data;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW:0]   count_q, count_d;

    logic [PW-1:0] head_nx;
    logic [PW-1:0] tail_nx;
    logic          keep0, keep1;
    logic          wr0_en, wr1_en;
    entry_t        wr0_ent, wr1_ent;
    entry_t        ent0, ent1;
    logic          pair, same;
    logic [1:0]    enq_cnt, deq_cnt;

    assign in_ready = (count_q <= (PW+1)'(DEPTH - 2));
    assign empty    = (count_q == '0);

    // Writes to r0 are architecturally void, so they never occupy a slot.
    assign keep0 = in0_valid && (in0_addr != 5'd0);
    assign keep1 = in1_valid && (in1_addr != 5'd0);

    assign tail_nx = tail_q + PW'(1);
    assign head_nx = head_q + PW'(1);

    always_comb begin
        wr0_en  = 1'b0;
        wr1_en  = 1'b0;
        wr0_ent = '{addr: in0_addr, data: in0_data};
        wr1_ent = '{addr: in1_addr, data: in1_data};
        if (in_ready) begin
            if (keep0) begin
                wr0_en = 1'b1;
                wr1_en = keep1;
            end else if (keep1) begin
                wr0_en  = 1'b1;
                wr0_ent = '{addr: in1_addr, data: in1_data};
            end
        end
        enq_cnt = {1'b0, wr0_en} + {1'b0, wr1_en};
    end

    assign ent0 = mem_q[head_q];
    assign ent1 = mem_q[head_nx];
    assign pair = (count_q >= (PW+1)'(2));
    // The younger write wins a same-register pair, so the older one is squashed.
    assign same = pair && (ent0.addr == ent1.addr);

    always_comb begin
        deq_cnt = 2'd0;
        if (pair) begin
            deq_cnt = 2'd2;
        end else if (count_q == (PW+1)'(1)) begin
            deq_cnt = 2'd1;
        end
    end

    // Reset gates the enables so entries discarded by a reset are never written.
    assign wen1   = !rst && (count_q != '0) && !same;
    assign waddr1 = ent0.addr;
    assign wdata1 = ent0.data;
    assign wen2   = !rst && pair;
    assign waddr2 = ent1.addr;
    assign wdata2 = ent1.data;

    always_comb begin
        head_d  = head_q + PW'(deq_cnt);
        tail_d  = tail_q + PW'(enq_cnt);
        count_d = count_q + {{(PW-1){1'b0}}, enq_cnt} - {{(PW-1){1'b0}}, deq_cnt};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (wr0_en) begin
                mem_q[tail_q] <= wr0_ent;
            end
            if (wr1_en) begin
                mem_q[tail_nx] <= wr1_ent;
            end
        end
    end

    // A slot is live when its distance from head is below count.
    always_comb begin
        logic [PW-1:0] off;
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - head_q;
            if ({1'b0, off} < count_q) begin
                busy_mask[mem_q[i].addr] = 1'b1;
            end
        end
        busy_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_reg_wb_queue.sv
// Directed bench for reg_wb_queue: reset, single/dual writes, r0 drop, same-register pairs, streaming wrap, mid-run reset.
`ifndef GRLEN
`define GRLEN 32
`endif

module tb_reg_wb_queue;

    logic              clk = 1'b0;
    logic              rst;
    logic              in0_valid;
    logic [4:0]        in0_addr;
    logic [`GRLEN-1:0] in0_data;
    logic              in1_valid;
    logic [4:0]        in1_addr;
    logic [`GRLEN-1:0] in1_data;
    logic              in_ready;
    logic [4:0]        waddr1;
    logic              wen1;
    logic [`GRLEN-1:0] wdata1;
    logic [4:0]        waddr2;
    logic              wen2;
    logic [`GRLEN-1:0] wdata2;
    logic [31:0]       busy_mask;
    logic              empty;

    int total = 0;
    int bad   = 0;

    reg_wb_queue #(.DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_addr  (in0_addr),
        .in0_data  (in0_data),
        .in1_valid (in1_valid),
        .in1_addr  (in1_addr),
        .in1_data  (in1_data),
        .in_ready  (in_ready),
        .waddr1    (waddr1),
        .wen1      (wen1),
        .wdata1    (wdata1),
        .waddr2    (waddr2),
        .wen2      (wen2),
        .wdata2    (wdata2),
        .busy_mask (busy_mask),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        in0_valid = v0;
        in0_addr  = a0;
        in0_data  = `GRLEN'(d0);
        in1_valid = v1;
        in1_addr  = a1;
        in1_data  = `GRLEN'(d1);
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_wen1"},  64'(wen1), 64'd0);
        chk({tag, "_wen2"},  64'(wen2), 64'd0);
        chk({tag, "_empty"}, 64'(empty), 64'd1);
        chk({tag, "_busy"},  64'(busy_mask), 64'd0);
    endtask

    initial begin
        logic [4:0]  a0, a1;
        logic [31:0] d0, d1;

        // Reset held two cycles while a valid result is presented.
        rst = 1'b1;
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
        tick();
        tick();
        chk_quiet("rst_hold");
        chk("rst_hold_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        idle();
        tick();
        chk_quiet("rst_rel");
        chk("rst_rel_ready", 64'(in_ready), 64'd1);

        // Single write.
        drive(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0);
        tick();
        idle();
        chk("single_wen1",   64'(wen1), 64'd1);
        chk("single_waddr1", 64'(waddr1), 64'd5);
        chk("single_wdata1", 64'(wdata1), 64'h1234_5678);
        chk("single_wen2",   64'(wen2), 64'd0);
        chk("single_busy",   64'(busy_mask), 64'h20);
        chk("single_empty",  64'(empty), 64'd0);
        tick();
        chk_quiet("single_done");

        // Dual write, order preserved.
        drive(1'b1, 5'd3, 32'hA, 1'b1, 5'd7, 32'hB);
        tick();
        chk("dual_wen1",   64'(wen1), 64'd1);
        chk("dual_waddr1", 64'(waddr1), 64'd3);
        chk("dual_wdata1", 64'(wdata1), 64'hA);
        chk("dual_wen2",   64'(wen2), 64'd1);
        chk("dual_waddr2", 64'(waddr2), 64'd7);
        chk("dual_wdata2", 64'(wdata2), 64'hB);
        chk("dual_busy",   64'(busy_mask), 64'h88);
        // r0 result dropped, r4 lands on port 1.
        drive(1'b1, 5'd0, 32'hC, 1'b1, 5'd4, 32'hD);
        tick();
        idle();
        chk("r0drop_wen1",   64'(wen1), 64'd1);
        chk("r0drop_waddr1", 64'(waddr1), 64'd4);
        chk("r0drop_wdata1", 64'(wdata1), 64'hD);
        chk("r0drop_wen2",   64'(wen2), 64'd0);
        chk("r0drop_busy",   64'(busy_mask), 64'h10);
        tick();
        chk_quiet("r0drop_done");

        // Younger slot only.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'hE);
        tick();
        idle();
        chk("in1only_wen1",   64'(wen1), 64'd1);
        chk("in1only_waddr1", 64'(waddr1), 64'd6);
        chk("in1only_wdata1", 64'(wdata1), 64'hE);
        chk("in1only_wen2",   64'(wen2), 64'd0);
        tick();
        chk_quiet("in1only_done");

        // Both results target r0: nothing stored.
        drive(1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22);
        tick();
        idle();
        chk_quiet("bothr0");

        // Same-register pair: only the younger value is written.
        drive(1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 32'h2);
        tick();
        idle();
        chk("same_wen1",   64'(wen1), 64'd0);
        chk("same_wen2",   64'(wen2), 64'd1);
        chk("same_waddr2", 64'(waddr2), 64'd9);
        chk("same_wdata2", 64'(wdata2), 64'h2);
        chk("same_busy",   64'(busy_mask), 64'h200);
        tick();
        chk_quiet("same_done");

        // Stream 20 distinct-address pairs back to back; pointers wrap several times.
        for (int k = 0; k < 20; k++) begin
            a0 = 5'(((2 * k) % 14) + 1);
            a1 = 5'(((2 * k + 1) % 14) + 1);
            d0 = 32'h100 + 32'(2 * k);
            d1 = 32'h100 + 32'(2 * k + 1);
            chk($sformatf("stream%0d_ready", k), 64'(in_ready), 64'd1);
            drive(1'b1, a0, d0, 1'b1, a1, d1);
            tick();
            chk($sformatf("stream%0d_wen1", k),   64'(wen1), 64'd1);
            chk($sformatf("stream%0d_waddr1", k), 64'(waddr1), 64'(a0));
            chk($sformatf("stream%0d_wdata1", k), 64'(wdata1), 64'(d0));
            chk($sformatf("stream%0d_wen2", k),   64'(wen2), 64'd1);
            chk($sformatf("stream%0d_waddr2", k), 64'(waddr2), 64'(a1));
            chk($sformatf("stream%0d_wdata2", k), 64'(wdata2), 64'(d1));
            chk($sformatf("stream%0d_busy", k),   64'(busy_mask), (64'd1 << a0) | (64'd1 << a1));
        end
        idle();
        tick();
        chk_quiet("stream_done");

        // Reset with entries queued: they must never reach the write ports.
        drive(1'b1, 5'd11, 32'h77, 1'b1, 5'd12, 32'h88);
        tick();
        idle();
        chk("midrst_pre_empty", 64'(empty), 64'd0);
        rst = 1'b1;
        #1;
        chk("midrst_hold_wen1", 64'(wen1), 64'd0);
        chk("midrst_hold_wen2", 64'(wen2), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk_quiet("midrst_rel");
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_quiet($sformatf("midrst_idle%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
